// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared types and constants for the pattern sequencer
//
// Purpose: FSM state encoding, default symbol geometry and the LFSR feedback
//          mask used when the pattern is reseeded (LFSR_RESEED_EN builds).
// Ports:   none (package).
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int SYM_W_DEF   = 2;
  localparam int MAX_LEN_DEF = 64 / SYM_W_DEF;

  // Galois feedback for taps 64,63,61,60.
  localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/pattern_lfsr64.sv
// rtl/pattern_lfsr64.sv - one-step 64-bit Galois LFSR next-state function
//
// Purpose: pure combinational next state of the pattern register when the
//          symbol slots wrap. An all-zero state would lock up the LFSR, so
//          it is treated as 64'h1 before stepping.
// Ports:
//   cur   in  64  current pattern
//   nxt   out 64  stepped pattern
module pattern_lfsr64
  import pattern_pkg::*;
(
  input  logic [63:0] cur,
  output logic [63:0] nxt
);

  logic [63:0] base;

  always_comb begin
    base = (cur == 64'd0) ? 64'd1 : cur;
    nxt  = (base >> 1) ^ (base[0] ? LFSR_MASK : 64'd0);
  end

endmodule

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - game-round symbol stream controller
//
// Purpose: on start, latches pattern = seed_x ^ seed_y and streams SYM_W-bit
//          symbols over a valid/ready handshake for round_len beats; a round
//          can be replayed from DONE without re-sampling the seed.
// Optional feature macro: LFSR_RESEED_EN (longer rounds; the pattern is
//          advanced by a 64-bit LFSR each time the symbol slots wrap).
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   seed_x     in   64     seed word x, sampled in LOAD
//   seed_y     in   64     seed word y, sampled in LOAD
//   start      in   1      begin new round (IDLE/DONE only)
//   replay     in   1      re-emit current round (DONE only)
//   round_len  in   LEN_W  requested symbols, sampled with start
//   sym_valid  out  1      sym/sym_idx valid
//   sym_ready  in   1      consumer accepts symbol
//   sym        out  SYM_W  current symbol
//   sym_idx    out  LEN_W  index of current symbol
//   busy       out  1      high in LOAD and EMIT
//   done       out  1      high in DONE
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int SYM_W   = SYM_W_DEF,
  parameter int LEN_W   = 6,
  parameter int MAX_LEN = 64 / SYM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      seed_x,
  input  logic [63:0]      seed_y,
  input  logic             start,
  input  logic             replay,
  input  logic [LEN_W-1:0] round_len,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic [SYM_W-1:0] sym,
  output logic [LEN_W-1:0] sym_idx,
  output logic             busy,
  output logic             done
);

  localparam int SLOTS  = 64 / SYM_W;
  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

`ifdef LFSR_RESEED_EN
  localparam logic [LEN_W-1:0] LEN_CAP = '1;
`else
  localparam logic [LEN_W-1:0] LEN_CAP = LEN_W'(MAX_LEN);
`endif

  state_t           state;
  logic [63:0]      pat;
  logic [63:0]      seed_pat;   // pattern as first latched, restored on replay
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] len_req;
  logic [SLOT_W-1:0] slot;
  logic             xfer;
  logic             last_beat;

  assign slot      = idx[SLOT_W-1:0];
  assign xfer      = sym_valid && sym_ready;
  assign last_beat = (idx == len - LEN_W'(1));
  assign sym       = pat[slot*SYM_W +: SYM_W];
  assign sym_idx   = idx;

  always_comb begin
    len_req = round_len;
    if (round_len == '0) begin
      len_req = LEN_W'(1);
    end else if (round_len > LEN_CAP) begin
      len_req = LEN_CAP;
    end
  end

`ifdef LFSR_RESEED_EN
  logic [63:0] pat_step;
  logic        slot_wrap;

  pattern_lfsr64 u_lfsr (
    .cur (pat),
    .nxt (pat_step)
  );

  assign slot_wrap = (slot == SLOT_W'(SLOTS - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pat       <= '0;
      seed_pat  <= '0;
      len       <= '0;
      idx       <= '0;
      sym_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            len   <= len_req;
            busy  <= 1'b1;
          end
        end

        LOAD: begin
          pat      <= seed_x ^ seed_y;
          seed_pat <= seed_x ^ seed_y;
          idx      <= '0;
          state    <= EMIT;
        end

        EMIT: begin
          // First EMIT cycle after LOAD only raises valid, giving the
          // two-edge start-to-valid latency with sym_valid as a flop.
          if (!sym_valid) begin
            sym_valid <= 1'b1;
          end else if (xfer) begin
`ifdef LFSR_RESEED_EN
            if (slot_wrap) begin
              pat <= pat_step;
            end
`endif
            if (last_beat) begin
              state     <= DONE;
              sym_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx <= idx + LEN_W'(1);
            end
          end
        end

        DONE: begin
          if (start) begin
            state <= LOAD;
            len   <= len_req;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else if (replay) begin
            state     <= EMIT;
            idx       <= '0;
            pat       <= seed_pat;
            sym_valid <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - scoreboard bench for pattern_sequencer
module tb_pattern_sequencer;

  localparam int SYM_W = 2;
  localparam int LEN_W = 6;
  localparam int SLOTS = 64 / SYM_W;
`ifdef LFSR_RESEED_EN
  localparam int CAP = 63;
`else
  localparam int CAP = 32;
`endif

  logic             clk;
  logic             rst_n;
  logic [63:0]      seed_x;
  logic [63:0]      seed_y;
  logic             start;
  logic             replay;
  logic [LEN_W-1:0] round_len;
  logic             sym_valid;
  logic             sym_ready;
  logic [SYM_W-1:0] sym;
  logic [LEN_W-1:0] sym_idx;
  logic             busy;
  logic             done;

  int vectors = 0;
  int errors  = 0;
  int last_idx = 0;
  logic [LEN_W+SYM_W-1:0] exp_q[$];

  localparam logic [63:0] SX1 = 64'h3A71628D53C493E6;
  localparam logic [63:0] SY1 = 64'hFA276435902E7342;

  pattern_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_x    (seed_x),
    .seed_y    (seed_y),
    .start     (start),
    .replay    (replay),
    .round_len (round_len),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym       (sym),
    .sym_idx   (sym_idx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] tb_lfsr(input logic [63:0] v);
    logic [63:0] b;
    b = (v == 64'd0) ? 64'd1 : v;
    return (b >> 1) ^ (b[0] ? 64'hD800_0000_0000_0000 : 64'd0);
  endfunction

  task automatic push_model(input logic [63:0] sx, input logic [63:0] sy, input int rl);
    logic [63:0] p;
    int n;
    int slot;
    p = sx ^ sy;
    n = (rl == 0) ? 1 : ((rl > CAP) ? CAP : rl);
    for (int i = 0; i < n; i++) begin
      slot = i % SLOTS;
      exp_q.push_back({LEN_W'(i), p[slot*SYM_W +: SYM_W]});
      if (slot == SLOTS - 1) p = tb_lfsr(p);
    end
    last_idx = n - 1;
  endtask

  task automatic do_start(input logic [63:0] sx, input logic [63:0] sy, input int rl, input bit with_replay);
    @(negedge clk);
    seed_x = sx; seed_y = sy; round_len = LEN_W'(rl);
    start = 1'b1; replay = with_replay;
    push_model(sx, sy, rl);
    @(posedge clk); #1;
    start = 1'b0; replay = 1'b0;
    vectors++;
    if (busy !== 1'b1 || sym_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL load_state: busy=%b valid=%b done=%b, required 1/0/0", busy, sym_valid, done);
    end
    @(posedge clk); #1;
    seed_x = {$urandom, $urandom};
    seed_y = {$urandom, $urandom};
    vectors++;
    if (sym_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_t1: sym_valid=%b, required 0", sym_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (sym_valid !== 1'b1 || sym_idx !== '0) begin
      errors++;
      $display("FAIL latency_t2: sym_valid=%b idx=%0d, required 1/0", sym_valid, sym_idx);
    end
  endtask

  task automatic stream(input bit toggle, input bit junk);
    bit rdy;
    bit have_hold;
    logic [LEN_W+SYM_W-1:0] held;
    logic [LEN_W+SYM_W-1:0] e;
    rdy = 1'b1;
    have_hold = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) break;
      sym_ready = rdy;
      if (junk) begin
        start = 1'b1; replay = 1'b1;
        seed_x = {$urandom, $urandom};
        round_len = LEN_W'($urandom);
      end
      if (have_hold && sym_valid) begin
        vectors++;
        if ({sym_idx, sym} !== held) begin
          errors++;
          $display("FAIL stall_hold: idx/sym=%h, required %h", {sym_idx, sym}, held);
        end
      end
      have_hold = 1'b0;
      if (sym_valid && sym_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: idx=%0d sym=%0d, required no beat", sym_idx, sym);
        end else begin
          e = exp_q.pop_front();
          if ({sym_idx, sym} !== e) begin
            errors++;
            $display("FAIL beat: idx=%0d sym=%0d, required idx=%0d sym=%0d",
                     sym_idx, sym, e[LEN_W+SYM_W-1:SYM_W], e[SYM_W-1:0]);
          end
        end
      end else if (sym_valid) begin
        have_hold = 1'b1;
        held = {sym_idx, sym};
      end
      if (toggle) rdy = !rdy;
    end
    start = 1'b0; replay = 1'b0; sym_ready = 1'b0;
    vectors++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL round_end: done=%b left=%0d, required done=1 left=0", done, exp_q.size());
    end
    vectors++;
    if (sym_valid !== 1'b0 || busy !== 1'b0 || sym_idx !== LEN_W'(last_idx)) begin
      errors++;
      $display("FAIL done_state: valid=%b busy=%b idx=%0d, required 0/0/%0d", sym_valid, busy, sym_idx, last_idx);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; replay = 1'b0; sym_ready = 1'b0;
    seed_x = '0; seed_y = '0; round_len = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({sym_valid, sym, sym_idx, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset: valid=%b sym=%0d idx=%0d busy=%b done=%b, required all 0",
               sym_valid, sym, sym_idx, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    do_start(SX1, SY1, 4, 1'b0);
    stream(1'b0, 1'b0);
  endtask

  task automatic test_stall;
    do_start(SX1, SY1, 4, 1'b0);
    stream(1'b1, 1'b1);
  endtask

  task automatic test_replay;
    @(negedge clk);
    seed_x = {$urandom, $urandom};
    replay = 1'b1;
    push_model(SX1, SY1, 4);
    @(posedge clk); #1;
    replay = 1'b0;
    vectors++;
    if (sym_valid !== 1'b1 || sym_idx !== '0 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL replay_entry: valid=%b idx=%0d done=%b busy=%b, required 1/0/0/1",
               sym_valid, sym_idx, done, busy);
    end
    stream(1'b0, 1'b0);
  endtask

  task automatic test_start_replay;
    do_start(64'h0123_4567_89AB_CDEF, 64'h0F0F_0F0F_F0F0_F0F0, 9, 1'b1);
    stream(1'b1, 1'b0);
  endtask

  task automatic test_len_bounds;
    do_start(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1'b0);
    stream(1'b0, 1'b0);
    do_start({$urandom, $urandom}, {$urandom, $urandom}, 63, 1'b0);
    stream(1'b0, 1'b0);
  endtask

  task automatic test_async_reset;
    do_start(SX1, SY1, 4, 1'b0);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (sym_idx == LEN_W'(2)) break;
      sym_ready = 1'b1;
    end
    sym_ready = 1'b0;
    vectors++;
    if (sym_idx !== LEN_W'(2) || sym_valid !== 1'b1) begin
      errors++;
      $display("FAIL reach_idx2: idx=%0d valid=%b, required 2/1", sym_idx, sym_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({sym_valid, sym, sym_idx, busy, done} !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b sym=%0d idx=%0d busy=%b done=%b, required all 0",
               sym_valid, sym, sym_idx, busy, done);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    do_start(SX1, SY1, 4, 1'b0);
    stream(1'b0, 1'b0);
  endtask

`ifdef LFSR_RESEED_EN
  task automatic test_lfsr;
    do_start(SX1, SY1, 40, 1'b0);
    stream(1'b1, 1'b0);
    @(negedge clk);
    replay = 1'b1;
    push_model(SX1, SY1, 40);
    @(posedge clk); #1;
    replay = 1'b0;
    stream(1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_replay();
    test_start_replay();
    test_len_bounds();
    test_async_reset();
`ifdef LFSR_RESEED_EN
    test_lfsr();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

endmodule
